// File: rtl/uart8_rx_fifo_pkg.sv
// Shared definitions for the Uart8 receive FIFO: data widths, default depth, entry layout.
package uart8_rx_fifo_pkg;

    localparam int unsigned UART8_DATA_W       = 8;
    localparam int unsigned UART8_RXFIFO_DEPTH = 16;
    localparam int unsigned UART8_ENTRY_W      = UART8_DATA_W + 1;

    // One FIFO entry: framing-error flag alongside the received byte.
    typedef struct packed {
        logic                    err;
        logic [UART8_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart8_fifo_mem.sv
// Register-array storage for the Uart8 receive FIFO: one write port, asynchronous read port.
module uart8_fifo_mem
    import uart8_rx_fifo_pkg::*;
#(
    parameter int unsigned Depth = UART8_RXFIFO_DEPTH,
    parameter int unsigned AddrW = 4
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  rx_entry_t        wr_data_i,
    input  logic [AddrW-1:0] rd_addr_i,
    output rx_entry_t        rd_data_o
);

    rx_entry_t mem_q [Depth];

    // Contents need no reset: the read side is qualified by the FIFO's valid flag.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart8_rx_fifo.sv
// Captures completed Uart8 bytes into a FIFO and presents them on a valid/ready stream,
// with sticky overrun and a saturating framing-error counter.
module uart8_rx_fifo
    import uart8_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = UART8_RXFIFO_DEPTH,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rxDone,
    input  logic                    rxErr,
    input  logic [UART8_DATA_W-1:0] rxOut,
    input  logic                    flush,
    input  logic                    clearStats,
    input  logic                    outReady,
    output logic                    outValid,
    output logic [UART8_DATA_W-1:0] outData,
    output logic                    outErr,
    output logic [ADDR_W:0]         level,
    output logic                    full,
    output logic                    overrun,
    output logic [ERR_CNT_W-1:0]    errCount
);

    localparam logic [ADDR_W:0]      PtrOne = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CntOne = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic                 rx_done_q;
    logic [ADDR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]      level_q, level_d;
    logic                 valid_q, valid_d;
    logic                 full_q, full_d;
    logic                 overrun_q, overrun_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic      push_evt, pop, do_push, dropped;
    rx_entry_t wr_entry, rd_entry;

    assign wr_entry = '{err: rxErr, data: rxOut};

    uart8_fifo_mem #(
        .Depth (DEPTH),
        .AddrW (ADDR_W)
    ) u_mem (
        .clk_i     (clk),
        .wr_en_i   (do_push),
        .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
        .wr_data_i (wr_entry),
        .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
        .rd_data_o (rd_entry)
    );

    // Next-state for pointers, occupancy flags and statistics.
    always_comb begin
        push_evt = rxDone & ~rx_done_q;
        pop      = valid_q & outReady;
        // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
        do_push  = push_evt & (~full_q | pop) & ~flush;
        dropped  = push_evt & full_q & ~pop & ~flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
            if (pop)     rd_ptr_d = rd_ptr_q + PtrOne;
        end

        // Flags come from the next pointers so they are registered alongside them.
        level_d = wr_ptr_d - rd_ptr_d;
        valid_d = (wr_ptr_d != rd_ptr_d);
        full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                  (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);

        // clearStats wins over an overrun or error arriving in the same cycle.
        err_cnt_d = err_cnt_q;
        overrun_d = overrun_q | dropped;
        if (clearStats) begin
            err_cnt_d = '0;
            overrun_d = 1'b0;
        end else if (push_evt && rxErr && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + CntOne;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            rx_done_q <= rxDone;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Head entry is forced to zero while empty so reset and flush present clean outputs.
    always_comb begin
        outValid = valid_q;
        outData  = valid_q ? rd_entry.data : '0;
        outErr   = valid_q & rd_entry.err;
        level    = level_q;
        full     = full_q;
        overrun  = overrun_q;
        errCount = err_cnt_q;
    end

endmodule

// File: tb/tb_uart8_rx_fifo.sv
// Self-checking bench for uart8_rx_fifo: directed scenarios plus randomized traffic, all
// compared against a queue-based reference model.
module tb_uart8_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxDone = 1'b0, rxErr = 1'b0, flush = 1'b0, clearStats = 1'b0, outReady = 1'b0;
    logic [7:0] rxOut = '0;
    logic       outValid, outErr, full, overrun;
    logic [7:0] outData, errCount;
    logic [4:0] level;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [8:0] mq[$];
    bit         m_prev = 1'b0;
    bit         m_ovr  = 1'b0;
    int         m_err  = 0;

    uart8_rx_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .rxDone     (rxDone),
        .rxErr      (rxErr),
        .rxOut      (rxOut),
        .flush      (flush),
        .clearStats (clearStats),
        .outReady   (outReady),
        .outValid   (outValid),
        .outData    (outData),
        .outErr     (outErr),
        .level      (level),
        .full       (full),
        .overrun    (overrun),
        .errCount   (errCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        int sz = mq.size();
        bit push = rxDone && !m_prev;
        bit pop  = (sz > 0) && outReady;
        if (clearStats) begin
            m_ovr = 1'b0;
            m_err = 0;
        end else if (push && rxErr && m_err < 255) begin
            m_err++;
        end
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (sz < DEPTH || pop) mq.push_back({rxErr, rxOut});
                else if (!clearStats) m_ovr = 1'b1;
            end
        end
        m_prev = rxDone;
    endtask

    task automatic compare_all();
        bit         v = mq.size() > 0;
        logic [8:0] h = v ? mq[0] : 9'h0;
        check("valid",    outValid, v);
        check("data",     outData,  h[7:0]);
        check("err",      outErr,   h[8]);
        check("level",    level,    mq.size());
        check("full",     full,     mq.size() == DEPTH);
        check("overrun",  overrun,  m_ovr);
        check("errcount", errCount, m_err);
    endtask

    // One clock: model sees the same inputs the DUT samples, outputs checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic pulse(input logic [7:0] d, input logic e);
        rxOut = d; rxErr = e; rxDone = 1'b1;
        step();
        rxDone = 1'b0;
        step();
    endtask

    task automatic mid_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_valid",   outValid, 0);
        check("rst_data",    outData,  0);
        check("rst_level",   level,    0);
        check("rst_full",    full,     0);
        check("rst_overrun", overrun,  0);
        check("rst_errcnt",  errCount, 0);
        mq.delete();
        m_prev = 1'b0;
        m_ovr  = 1'b0;
        m_err  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #3;
        check("init_valid", outValid, 0);
        check("init_level", level, 0);
        check("init_err",   outErr, 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: single byte in and out
        rxOut = 8'h56; rxErr = 1'b0; rxDone = 1'b1;
        step();
        check("t1_valid", outValid, 1);
        check("t1_data",  outData, 8'h56);
        check("t1_level", level, 1);
        rxDone = 1'b0; outReady = 1'b1;
        step();
        check("t1_empty", outValid, 0);
        outReady = 1'b0;

        // 2: long rxDone level gives one entry
        rxOut = 8'hA5; rxDone = 1'b1;
        repeat (50) step();
        check("t2_level", level, 1);
        rxDone = 1'b0; outReady = 1'b1;
        step();
        outReady = 1'b0;

        // 3: fill, overrun, drain in order
        for (int i = 0; i < 16; i++) pulse(8'(i), 1'b0);
        check("t3_full",  full, 1);
        check("t3_level", level, 16);
        pulse(8'hFF, 1'b0);
        check("t3_overrun", overrun, 1);
        check("t3_level17", level, 16);
        outReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_order", outData, i);
            step();
        end
        outReady = 1'b0;
        clearStats = 1'b1;
        step();
        clearStats = 1'b0;

        // 4: push and pop together while full, then wrap with concurrent traffic
        for (int i = 0; i < 16; i++) pulse(8'(i + 32), 1'b0);
        rxOut = 8'h77; rxDone = 1'b1; outReady = 1'b1;
        step();
        rxDone = 1'b0; outReady = 1'b0;
        check("t4_level",   level, 16);
        check("t4_overrun", overrun, 0);
        check("t4_head",    outData, 8'h21);
        outReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rxOut = 8'(i + 100); rxDone = (i % 2 == 0);
            step();
        end
        rxDone = 1'b0;
        repeat (20) step();
        check("t4_drained", level, 0);

        // 5: saturating error counter
        for (int i = 0; i < 300; i++) pulse(8'(i), 1'b1);
        check("t5_sat", errCount, 8'hFF);
        outReady = 1'b0;
        clearStats = 1'b1;
        step();
        clearStats = 1'b0;
        check("t5_clear", errCount, 0);
        check("t5_ovr",   overrun, 0);

        // 6: flush with concurrent push, then reset mid-stream with rxDone high
        for (int i = 0; i < 5; i++) pulse(8'(i + 200), 1'b0);
        check("t6_level5", level, 5);
        flush = 1'b1; rxOut = 8'h99; rxDone = 1'b1;
        step();
        flush = 1'b0; rxDone = 1'b0;
        check("t6_flush_level", level, 0);
        check("t6_flush_valid", outValid, 0);
        for (int i = 0; i < 3; i++) pulse(8'(i + 210), 1'b1);
        rxOut = 8'h3C; rxErr = 1'b0; rxDone = 1'b1;
        mid_reset();
        step();
        check("t6_release_push", level, 1);
        check("t6_release_data", outData, 8'h3C);
        rxDone = 1'b0;
        step();

        // Randomized traffic: fill-biased then drain-biased phases
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                rxDone     = ($urandom_range(0, 99) < 50);
                rxErr      = ($urandom_range(0, 3) == 0);
                rxOut      = 8'($urandom);
                outReady   = ($urandom_range(0, 99) < (ph == 0 ? 20 : 80));
                flush      = ($urandom_range(0, 63) == 0);
                clearStats = ($urandom_range(0, 63) == 0);
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
